// File: rtl/gc_pkg.sv
// Shared types and protocol constants for the GameCube controller poll scheduler.
package gc_pkg;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      StSendId,
      StWaitId,
      StSendOrigin,
      StWaitOrigin,
      StIdle,
      StSendPoll,
      StWaitPoll
   } gc_state_e;

   // Command bytes
   localparam logic [7:0] CMD_ID       = 8'h00;
   localparam logic [7:0] CMD_ORIGIN   = 8'h41;
   localparam logic [7:0] CMD_POLL     = 8'h40;
   localparam logic [7:0] CMD_POLL_ARG = 8'h03;

   // First byte of a standard controller ID reply
   localparam logic [7:0] ID_BYTE0 = 8'h09;

   // Expected response lengths in bytes
   localparam logic [3:0] RSP_LEN_ID     = 4'd3;
   localparam logic [3:0] RSP_LEN_ORIGIN = 4'd10;
   localparam logic [3:0] RSP_LEN_POLL   = 4'd8;

   // Neutral stick value
   localparam logic [7:0] STICK_CENTER = 8'h80;

endpackage

// File: rtl/gc_stick_cal.sv
// Origin calibration for one stick axis: raw - origin + 128, clamped to 0..255.
module gc_stick_cal (
   input  logic [7:0] i_raw,
   input  logic [7:0] i_origin,
   output logic [7:0] o_cal
);

   logic signed [9:0] w_sum;

   assign w_sum = $signed({2'b00, i_raw}) - $signed({2'b00, i_origin}) + 10'sd128;

   // Clamp the signed sum into the unsigned 8-bit range
   always_comb begin
      o_cal = w_sum[7:0];
      if (w_sum < 10'sd0) begin
         o_cal = 8'h00;
      end else if (w_sum > 10'sd255) begin
         o_cal = 8'hFF;
      end
   end

endmodule

// File: rtl/gc_poll_scheduler.sv
// Identifies, calibrates and periodically polls a GameCube controller through
// a byte-level transceiver, publishing calibrated controller state.
module gc_poll_scheduler
   import gc_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 300000,
   parameter int unsigned TIMEOUT_CYC = 25000,
   parameter int unsigned MAX_MISS    = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rumble,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   output logic [1:0]  o_cmd_len,
   output logic [23:0] o_cmd_data,
   input  logic        i_rsp_valid,
   input  logic        i_rsp_err,
   input  logic [3:0]  i_rsp_len,
   input  logic [79:0] i_rsp_data,
   output logic        o_connected,
   output logic [15:0] o_buttons,
   output logic [7:0]  o_joy_x,
   output logic [7:0]  o_joy_y,
   output logic [7:0]  o_cstick_x,
   output logic [7:0]  o_cstick_y,
   output logic [7:0]  o_ltrig,
   output logic [7:0]  o_rtrig,
   output logic        o_frame,
   output logic [7:0]  o_overruns
);

   localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned MW = $clog2(MAX_MISS + 1);

   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);

   gc_state_e     r_state;
   gc_state_e     w_state_nxt;

   logic [PW-1:0] r_poll_timer;
   logic [TW-1:0] r_to_cnt;
   logic [MW-1:0] r_miss_cnt;
   logic          r_pending;
   logic [7:0]    r_overruns;

   logic [1:0]    r_cmd_len;
   logic [23:0]   r_cmd_data;

   logic          r_connected;
   logic [15:0]   r_buttons;
   logic [7:0]    r_joy_x;
   logic [7:0]    r_joy_y;
   logic [7:0]    r_cstick_x;
   logic [7:0]    r_cstick_y;
   logic [7:0]    r_ltrig;
   logic [7:0]    r_rtrig;
   logic          r_frame;

   logic [7:0]    r_org_jx;
   logic [7:0]    r_org_jy;
   logic [7:0]    r_org_cx;
   logic [7:0]    r_org_cy;

   logic          w_tick;
   logic          w_in_wait;
   logic          w_to_exp;
   logic          w_rsp_clean;
   logic          w_good_id;
   logic          w_good_org;
   logic          w_good_poll;
   logic          w_accept;
   logic          w_link_miss;
   logic          w_org_ok;
   logic          w_poll_ok;
   logic          w_poll_miss;
   logic          w_drop;

   logic [7:0]    w_cal_jx;
   logic [7:0]    w_cal_jy;
   logic [7:0]    w_cal_cx;
   logic [7:0]    w_cal_cy;

   // Trailing origin bytes carry nothing this block uses
   logic          w_unused_rsp;
   assign w_unused_rsp = ^i_rsp_data[15:0];

   assign w_tick    = (r_poll_timer == POLL_LAST);
   assign w_in_wait = (r_state == StWaitId) || (r_state == StWaitOrigin) ||
                      (r_state == StWaitPoll);
   assign w_to_exp  = (r_to_cnt == TO_LAST);

   assign w_rsp_clean = i_rsp_valid & ~i_rsp_err;
   assign w_good_id   = w_rsp_clean & (i_rsp_len == RSP_LEN_ID) &
                        (i_rsp_data[79:72] == ID_BYTE0);
   assign w_good_org  = w_rsp_clean & (i_rsp_len == RSP_LEN_ORIGIN);
   assign w_good_poll = w_rsp_clean & (i_rsp_len == RSP_LEN_POLL);

   assign w_drop = w_poll_miss & (r_miss_cnt == MISS_LAST);

   gc_stick_cal u_cal_jx (.i_raw(i_rsp_data[63:56]), .i_origin(r_org_jx), .o_cal(w_cal_jx));
   gc_stick_cal u_cal_jy (.i_raw(i_rsp_data[55:48]), .i_origin(r_org_jy), .o_cal(w_cal_jy));
   gc_stick_cal u_cal_cx (.i_raw(i_rsp_data[47:40]), .i_origin(r_org_cx), .o_cal(w_cal_cx));
   gc_stick_cal u_cal_cy (.i_raw(i_rsp_data[39:32]), .i_origin(r_org_cy), .o_cal(w_cal_cy));

   // State register; reset parks in idle with a tick pending so ID goes out at once
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and transaction outcome decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_link_miss = 1'b0;
      w_org_ok    = 1'b0;
      w_poll_ok   = 1'b0;
      w_poll_miss = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_tick || r_pending) begin
               w_state_nxt = r_connected ? StSendPoll : StSendId;
            end
         end
         StSendId: begin
            if (i_cmd_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = StWaitId;
            end
         end
         StSendOrigin: begin
            if (i_cmd_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = StWaitOrigin;
            end
         end
         StSendPoll: begin
            if (i_cmd_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = StWaitPoll;
            end
         end
         StWaitId: begin
            if (w_good_id) begin
               w_state_nxt = StSendOrigin;
            end else if (i_rsp_valid || w_to_exp) begin
               w_link_miss = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         StWaitOrigin: begin
            if (w_good_org) begin
               w_org_ok    = 1'b1;
               w_state_nxt = StIdle;
            end else if (i_rsp_valid || w_to_exp) begin
               w_link_miss = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         StWaitPoll: begin
            if (w_good_poll) begin
               w_poll_ok   = 1'b1;
               w_state_nxt = StIdle;
            end else if (i_rsp_valid || w_to_exp) begin
               w_poll_miss = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Free-running poll period timer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_poll_timer <= '0;
      end else if (w_tick) begin
         r_poll_timer <= '0;
      end else begin
         r_poll_timer <= r_poll_timer + PW'(1);
      end
   end

   // One-deep tick memory while busy; a second busy tick counts as an overrun
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending  <= 1'b1;
         r_overruns <= 8'h00;
      end else if (r_state == StIdle) begin
         r_pending <= 1'b0;
      end else if (w_tick) begin
         if (!r_pending) begin
            r_pending <= 1'b1;
         end else if (r_overruns != 8'hFF) begin
            r_overruns <= r_overruns + 8'd1;
         end
      end
   end

   // Response timeout counter, restarted on command acceptance
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_to_cnt <= '0;
      end else if (w_accept) begin
         r_to_cnt <= '0;
      end else if (w_in_wait && !w_to_exp) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   // Command bytes captured on entry to a send state; rumble sampled here
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cmd_len  <= 2'd0;
         r_cmd_data <= 24'h000000;
      end else if (w_state_nxt != r_state) begin
         case (w_state_nxt)
            StSendId: begin
               r_cmd_len  <= 2'd1;
               r_cmd_data <= {CMD_ID, 16'h0000};
            end
            StSendOrigin: begin
               r_cmd_len  <= 2'd1;
               r_cmd_data <= {CMD_ORIGIN, 16'h0000};
            end
            StSendPoll: begin
               r_cmd_len  <= 2'd3;
               r_cmd_data <= {CMD_POLL, CMD_POLL_ARG, 7'b0, i_rumble};
            end
            default: begin
            end
         endcase
      end
   end

   // Link status and consecutive poll miss counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_connected <= 1'b0;
         r_miss_cnt  <= '0;
      end else if (w_org_ok) begin
         r_connected <= 1'b1;
         r_miss_cnt  <= '0;
      end else if (w_link_miss) begin
         r_connected <= 1'b0;
      end else if (w_poll_ok) begin
         r_miss_cnt <= '0;
      end else if (w_drop) begin
         r_connected <= 1'b0;
         r_miss_cnt  <= '0;
      end else if (w_poll_miss) begin
         r_miss_cnt <= r_miss_cnt + MW'(1);
      end
   end

   // Stick origins latched from the origin reply (same byte layout as a poll)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_org_jx <= STICK_CENTER;
         r_org_jy <= STICK_CENTER;
         r_org_cx <= STICK_CENTER;
         r_org_cy <= STICK_CENTER;
      end else if (w_org_ok) begin
         r_org_jx <= i_rsp_data[63:56];
         r_org_jy <= i_rsp_data[55:48];
         r_org_cx <= i_rsp_data[47:40];
         r_org_cy <= i_rsp_data[39:32];
      end
   end

   // Controller state outputs and frame strobe
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buttons  <= 16'h0000;
         r_joy_x    <= STICK_CENTER;
         r_joy_y    <= STICK_CENTER;
         r_cstick_x <= STICK_CENTER;
         r_cstick_y <= STICK_CENTER;
         r_ltrig    <= 8'h00;
         r_rtrig    <= 8'h00;
         r_frame    <= 1'b0;
      end else begin
         r_frame <= w_poll_ok;
         if (w_poll_ok) begin
            r_buttons  <= i_rsp_data[79:64];
            r_joy_x    <= w_cal_jx;
            r_joy_y    <= w_cal_jy;
            r_cstick_x <= w_cal_cx;
            r_cstick_y <= w_cal_cy;
            r_ltrig    <= i_rsp_data[31:24];
            r_rtrig    <= i_rsp_data[23:16];
         end else if (w_drop) begin
            r_buttons  <= 16'h0000;
            r_joy_x    <= STICK_CENTER;
            r_joy_y    <= STICK_CENTER;
            r_cstick_x <= STICK_CENTER;
            r_cstick_y <= STICK_CENTER;
            r_ltrig    <= 8'h00;
            r_rtrig    <= 8'h00;
         end
      end
   end

   assign o_cmd_valid = (r_state == StSendId) || (r_state == StSendOrigin) ||
                        (r_state == StSendPoll);
   assign o_cmd_len   = r_cmd_len;
   assign o_cmd_data  = r_cmd_data;
   assign o_connected = r_connected;
   assign o_buttons   = r_buttons;
   assign o_joy_x     = r_joy_x;
   assign o_joy_y     = r_joy_y;
   assign o_cstick_x  = r_cstick_x;
   assign o_cstick_y  = r_cstick_y;
   assign o_ltrig     = r_ltrig;
   assign o_rtrig     = r_rtrig;
   assign o_frame     = r_frame;
   assign o_overruns  = r_overruns;

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// Directed plus randomized bench for gc_poll_scheduler with a behavioural model.
module tb_gc_poll_scheduler;

   localparam int unsigned POLL_PERIOD = 100;
   localparam int unsigned TIMEOUT_CYC = 40;
   localparam int unsigned MAX_MISS    = 3;

   logic        clk;
   logic        rst_n;
   logic        rumble;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_len;
   logic [23:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_err;
   logic [3:0]  rsp_len;
   logic [79:0] rsp_data;
   logic        connected;
   logic [15:0] buttons;
   logic [7:0]  joy_x, joy_y, cstick_x, cstick_y, ltrig, rtrig;
   logic        frame;
   logic [7:0]  overruns;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Reference model state
   bit          m_conn;
   int          m_miss;
   logic [15:0] m_btn;
   logic [7:0]  m_stk[4];
   logic [7:0]  m_lt, m_rt;
   logic [7:0]  m_org[4];
   bit          rnd_rumble;

   gc_poll_scheduler #(
      .POLL_PERIOD(POLL_PERIOD),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .MAX_MISS   (MAX_MISS)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rumble   (rumble),
      .o_cmd_valid(cmd_valid),
      .i_cmd_ready(cmd_ready),
      .o_cmd_len  (cmd_len),
      .o_cmd_data (cmd_data),
      .i_rsp_valid(rsp_valid),
      .i_rsp_err  (rsp_err),
      .i_rsp_len  (rsp_len),
      .i_rsp_data (rsp_data),
      .o_connected(connected),
      .o_buttons  (buttons),
      .o_joy_x    (joy_x),
      .o_joy_y    (joy_y),
      .o_cstick_x (cstick_x),
      .o_cstick_y (cstick_y),
      .o_ltrig    (ltrig),
      .o_rtrig    (rtrig),
      .o_frame    (frame),
      .o_overruns (overruns)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] cal(input logic [7:0] raw, input logic [7:0] org);
      int v;
      v = int'(raw) - int'(org) + 128;
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      return 8'(v);
   endfunction

   task automatic model_reset();
      m_conn = 0;
      m_miss = 0;
      m_btn  = 16'h0000;
      m_lt   = 8'h00;
      m_rt   = 8'h00;
      for (int i = 0; i < 4; i++) begin
         m_stk[i] = 8'h80;
         m_org[i] = 8'h80;
      end
   endtask

   task automatic model_miss();
      m_miss++;
      if (m_miss == MAX_MISS) begin
         m_conn = 0;
         m_miss = 0;
         m_btn  = 16'h0000;
         m_lt   = 8'h00;
         m_rt   = 8'h00;
         for (int i = 0; i < 4; i++) m_stk[i] = 8'h80;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_conn"}, connected, m_conn);
      chk({tag, "_btn"}, buttons, m_btn);
      chk({tag, "_jx"}, joy_x, m_stk[0]);
      chk({tag, "_jy"}, joy_y, m_stk[1]);
      chk({tag, "_cx"}, cstick_x, m_stk[2]);
      chk({tag, "_cy"}, cstick_y, m_stk[3]);
      chk({tag, "_lt"}, ltrig, m_lt);
      chk({tag, "_rt"}, rtrig, m_rt);
   endtask

   // Wait for an offered command, check it, then accept it for one cycle
   task automatic accept_cmd(input logic [1:0] el, input logic [23:0] ed, input int budget,
                             input string tag);
      int n = 0;
      while (cmd_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, cmd_valid, 1'b1);
      chk({tag, "_len"}, cmd_len, el);
      chk({tag, "_data"}, cmd_data, ed);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic pulse_rsp(input logic [3:0] len, input logic [79:0] data, input logic err);
      if (rnd_rumble) rumble = 1'($urandom);
      repeat ($urandom_range(1, 6)) @(negedge clk);
      rsp_valid = 1'b1;
      rsp_len   = len;
      rsp_data  = data;
      rsp_err   = err;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
   endtask

   task automatic do_identify(input int budget, input logic [7:0] o0, input logic [7:0] o1,
                              input logic [7:0] o2, input logic [7:0] o3);
      accept_cmd(2'd1, 24'h000000, budget, "id_cmd");
      pulse_rsp(4'd3, {8'h09, 8'h00, 8'h03, 56'h0}, 1'b0);
      accept_cmd(2'd1, 24'h410000, 6, "origin_cmd");
      pulse_rsp(4'd10, {16'h0000, o0, o1, o2, o3, 32'h0}, 1'b0);
      m_org[0] = o0;
      m_org[1] = o1;
      m_org[2] = o2;
      m_org[3] = o3;
      m_conn   = 1;
      m_miss   = 0;
      chk("identify_conn", connected, 1'b1);
   endtask

   task automatic do_poll_good(input logic [63:0] b, input string tag);
      pulse_rsp(4'd8, {b, 16'h0000}, 1'b0);
      m_btn    = b[63:48];
      m_stk[0] = cal(b[47:40], m_org[0]);
      m_stk[1] = cal(b[39:32], m_org[1]);
      m_stk[2] = cal(b[31:24], m_org[2]);
      m_stk[3] = cal(b[23:16], m_org[3]);
      m_lt     = b[15:8];
      m_rt     = b[7:0];
      m_miss   = 0;
      check_outputs(tag);
      chk({tag, "_frame_hi"}, frame, 1'b1);
      @(negedge clk);
      chk({tag, "_frame_lo"}, frame, 1'b0);
   endtask

   initial begin
      int          act;
      int          frames;
      logic [3:0]  bl;

      rst_n      = 1'b0;
      rumble     = 1'b0;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rsp_len    = 4'd0;
      rsp_data   = '0;
      rnd_rumble = 0;
      model_reset();
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_frame", frame, 1'b0);
      chk("rst_overruns", overruns, 8'h00);
      check_outputs("rst");
      rst_n = 1'b1;

      // Identification straight after reset, origin all centred
      do_identify(3, 8'h80, 8'h80, 8'h80, 8'h80);

      // First poll with known bytes
      accept_cmd(2'd3, 24'h400300, 4 * POLL_PERIOD, "poll1");
      do_poll_good(64'h0080A06080801020, "poll1");
      chk("poll1_jx_const", joy_x, 8'hA0);
      chk("poll1_jy_const", joy_y, 8'h60);
      chk("poll1_lt_const", ltrig, 8'h10);

      // Stray response while idle must be ignored
      pulse_rsp(4'd8, {64'hFFFF11223344AABB, 16'h0}, 1'b0);
      chk("stray_frame", frame, 1'b0);
      check_outputs("stray");

      // Rumble reflected in the poll command, then three silent polls disconnect
      rumble = 1'b1;
      for (int i = 0; i < MAX_MISS; i++) begin
         accept_cmd(2'd3, 24'h400301, 4 * POLL_PERIOD, "silent_poll");
         repeat (TIMEOUT_CYC + 5) @(negedge clk);
         chk("silent_frame", frame, 1'b0);
         model_miss();
      end
      check_outputs("disc");
      chk("disc_jx_const", joy_x, 8'h80);

      // Reconnect with offset origins and exercise both clamp limits
      do_identify(4 * POLL_PERIOD, 8'h70, 8'h90, 8'h80, 8'h80);
      accept_cmd(2'd3, 24'h400301, 4 * POLL_PERIOD, "clamp_poll");
      do_poll_good(64'h0000F80580800000, "clamp");
      chk("clamp_hi", joy_x, 8'hFF);
      chk("clamp_lo", joy_y, 8'h00);

      // Randomized traffic against the model
      rnd_rumble = 1;
      for (int it = 0; it < 14; it++) begin
         if (!m_conn) begin
            do_identify(4 * POLL_PERIOD, 8'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom));
         end else begin
            accept_cmd(2'd3, {8'h40, 8'h03, 7'b0, rumble}, 4 * POLL_PERIOD, "rnd_poll");
            act = $urandom_range(0, 9);
            if (act < 6) begin
               do_poll_good({$urandom, $urandom}, "rnd_good");
            end else if (act < 8) begin
               bl = 4'($urandom_range(0, 15));
               if (act == 7 && bl == 4'd8) bl = 4'd9;
               pulse_rsp(bl, {$urandom, $urandom, 16'h0}, act == 6);
               model_miss();
               chk("rnd_bad_frame", frame, 1'b0);
               check_outputs("rnd_bad");
            end else begin
               if (rnd_rumble) rumble = 1'($urandom);
               repeat (TIMEOUT_CYC + 5) @(negedge clk);
               model_miss();
               check_outputs("rnd_silent");
            end
         end
      end
      rnd_rumble = 0;

      // Reset in the middle of a poll, with a response arriving around release
      if (!m_conn) do_identify(4 * POLL_PERIOD, 8'h80, 8'h80, 8'h80, 8'h80);
      accept_cmd(2'd3, {8'h40, 8'h03, 7'b0, rumble}, 4 * POLL_PERIOD, "rst_poll");
      repeat (2) @(negedge clk);
      rst_n     = 1'b0;
      rsp_valid = 1'b1;
      rsp_len   = 4'd8;
      rsp_err   = 1'b0;
      rsp_data  = {64'h1234A0A0A0A0FFFF, 16'h0};
      model_reset();
      @(negedge clk);
      chk("midrst_frame", frame, 1'b0);
      chk("midrst_overruns", overruns, 8'h00);
      check_outputs("midrst");
      rst_n = 1'b1;

      // Transceiver stalls for 350 cycles: one tick pending, two overruns
      frames = 0;
      for (int c = 0; c < 350; c++) begin
         @(negedge clk);
         rsp_valid = 1'b0;
         if (frame === 1'b1) frames++;
      end
      chk("stall_frames", frames, 0);
      chk("stall_cmd_valid", cmd_valid, 1'b1);
      chk("stall_cmd_data", cmd_data, 24'h000000);
      chk("stall_overruns", overruns, 8'h02);
      check_outputs("stall");

      // The pending tick issues a poll right after identification
      do_identify(3, 8'h80, 8'h80, 8'h80, 8'h80);
      accept_cmd(2'd3, {8'h40, 8'h03, 7'b0, rumble}, 4, "pending_poll");
      do_poll_good(64'h0102030405060708, "pending");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
